flag_unit: RTL and testbench

- Downstream consumer of the 64-bit AND-reduction block, sitting between the EX-stage ALU and branch resolution in the pipelined ARM64 core.
- Zero detection: two AND-reduction instances, each fed the bitwise inverse of a 64-bit value:
  - one on the ALU result, producing the Z flag;
  - one on the CBZ operand, producing the CBZ test.
- Holds the architectural NZCV flag register, written by flag-setting instructions (ADDS/SUBS).
- Forwards in-flight flags so a B.cond in the same cycle as a flag-setting instruction resolves correctly.
- Produces the branch-taken decision for the fetch stage.

---
 rtl/flag_unit_if.sv | 27 ++
 rtl/flag_unit.sv | 82 ++++++++
 tb/tb_flag_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/flag_unit_if.sv
// EX-stage to flag unit bundle: ALU result/status and branch request in,
// registered NZCV, zero-detect and branch decision out.
interface flag_unit_if;
  logic [63:0] alu_result;
  logic        alu_carry;
  logic        alu_overflow;
  logic        set_flags;
  logic        stall;
  logic [63:0] cbz_value;
  logic [1:0]  br_type;
  logic        flag_n;
  logic        flag_z;
  logic        flag_c;
  logic        flag_v;
  logic        ex_zero;
  logic        branch_taken;

  modport master (
    output alu_result, alu_carry, alu_overflow, set_flags, stall, cbz_value, br_type,
    input  flag_n, flag_z, flag_c, flag_v, ex_zero, branch_taken
  );

  modport slave (
    input  alu_result, alu_carry, alu_overflow, set_flags, stall, cbz_value, br_type,
    output flag_n, flag_z, flag_c, flag_v, ex_zero, branch_taken
  );
endinterface

// File: rtl/flag_unit.sv
// NZCV flag register with EX->branch forwarding, zero detection via 64-bit
// AND-reduction of inverted operands, and branch-taken resolution.
module and_reduce64 (
  input  logic [63:0] din,
  output logic        all_ones
);
  assign all_ones = &din;
endmodule

module flag_unit #(
  parameter int WIDTH = 64  // only 64 is valid: the zero-detect instances are fixed width
) (
  input  logic      clk,
  input  logic      reset,
  flag_unit_if.slave bus
);
  typedef enum logic [1:0] {
    BR_NONE   = 2'b00,
    BR_LT     = 2'b01,
    BR_CBZ    = 2'b10,
    BR_ALWAYS = 2'b11
  } br_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  nzcv_t       flags_q;
  logic [63:0] alu_inv;
  logic [63:0] cbz_inv;
  logic        ex_zero;
  logic        cbz_zero;
  logic        write_en;
  logic        eff_n;
  logic        eff_v;
  logic        branch_taken;

  assign alu_inv = ~bus.alu_result;
  assign cbz_inv = ~bus.cbz_value;

  and_reduce64 u_ex_zero  (.din(alu_inv), .all_ones(ex_zero));
  and_reduce64 u_cbz_zero (.din(cbz_inv), .all_ones(cbz_zero));

  // A stalled flag-setting instruction neither writes nor forwards.
  assign write_en = bus.set_flags & ~bus.stall;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
    end else if (write_en) begin
      flags_q <= '{n: bus.alu_result[WIDTH-1], z: ex_zero,
                   c: bus.alu_carry,           v: bus.alu_overflow};
    end
  end

  assign eff_n = write_en ? bus.alu_result[WIDTH-1] : flags_q.n;
  assign eff_v = write_en ? bus.alu_overflow        : flags_q.v;

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    branch_taken = 1'b0;
    case (br_e'(bus.br_type))
      BR_NONE:   branch_taken = 1'b0;
      BR_LT:     branch_taken = eff_n ^ eff_v;
      BR_CBZ:    branch_taken = cbz_zero;
      BR_ALWAYS: branch_taken = 1'b1;
      default:   branch_taken = 1'b0;
    endcase
  end

  assign bus.flag_n       = flags_q.n;
  assign bus.flag_z       = flags_q.z;
  assign bus.flag_c       = flags_q.c;
  assign bus.flag_v       = flags_q.v;
  assign bus.ex_zero      = ex_zero;
  assign bus.branch_taken = branch_taken;
endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: expectations are queued when stimulus is
// driven and compared against the DUT once its outputs have settled.
module tb_flag_unit;
  typedef enum logic [1:0] {S_FLAGS, S_ZERO, S_BR} sel_e;
  typedef struct packed {
    sel_e       sel;
    logic [3:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;
  exp_t  exp_q[$];
  string tag_q[$];

  flag_unit_if bus ();
  flag_unit dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_val(input string tag, input sel_e sel, input logic [3:0] val);
    exp_q.push_back('{sel: sel, val: val});
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    exp_t       e;
    string      t;
    logic [3:0] obs;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      case (e.sel)
        S_FLAGS: obs = {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v};
        S_ZERO:  obs = {3'b000, bus.ex_zero};
        default: obs = {3'b000, bus.branch_taken};
      endcase
      vectors++;
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %b expected %b", t, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic alu(input logic [63:0] res, input logic c, input logic v, input logic sf);
    bus.alu_result   = res;
    bus.alu_carry    = c;
    bus.alu_overflow = v;
    bus.set_flags    = sf;
  endtask

  initial begin
    reset            = 1'b1;
    bus.alu_result   = '0;
    bus.alu_carry    = 1'b0;
    bus.alu_overflow = 1'b0;
    bus.set_flags    = 1'b0;
    bus.stall        = 1'b0;
    bus.cbz_value    = 64'h1;
    bus.br_type      = 2'b00;
    expect_val("reset_flags", S_FLAGS, 4'b0000);
    settle();
    tick();
    reset = 1'b0;

    // Reset: load flags, then assert reset between edges
    alu(64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b1);
    tick();
    expect_val("preload_1011", S_FLAGS, 4'b1011);
    drain();
    #2;
    reset = 1'b1;
    alu(64'h0, 1'b1, 1'b1, 1'b1);
    expect_val("async_reset", S_FLAGS, 4'b0000);
    settle();
    tick();
    tick();
    expect_val("reset_holds", S_FLAGS, 4'b0000);
    drain();
    reset = 1'b0;
    alu(64'h0, 1'b0, 1'b0, 1'b1);
    tick();
    expect_val("first_edge_after_reset", S_FLAGS, 4'b0100);
    drain();

    // Zero detect on ALU result and CBZ operand
    alu(64'h0, 1'b0, 1'b0, 1'b0);
    expect_val("ex_zero_all0", S_ZERO, 4'b0001);
    settle();
    for (int i = 0; i < 64; i++) begin
      bus.alu_result = 64'h1 << i;
      expect_val($sformatf("ex_zero_bit%0d", i), S_ZERO, 4'b0000);
      settle();
    end
    bus.br_type   = 2'b10;
    bus.cbz_value = 64'h0;
    expect_val("cbz_zero_all0", S_BR, 4'b0001);
    settle();
    for (int i = 0; i < 64; i++) begin
      bus.cbz_value = 64'h1 << i;
      expect_val($sformatf("cbz_bit%0d", i), S_BR, 4'b0000);
      settle();
    end
    bus.br_type = 2'b00;

    // Flag capture, hold, and back-to-back writes
    alu(64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
    expect_val("ex_zero_msb", S_ZERO, 4'b0000);
    settle();
    tick();
    expect_val("capture_1010", S_FLAGS, 4'b1010);
    drain();
    alu(64'h0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_val("hold_no_set", S_FLAGS, 4'b1010);
    drain();
    alu(64'h0, 1'b0, 1'b1, 1'b1);
    tick();
    expect_val("b2b_first_0101", S_FLAGS, 4'b0101);
    drain();
    alu(64'h5, 1'b1, 1'b0, 1'b1);
    tick();
    expect_val("b2b_second_0010", S_FLAGS, 4'b0010);
    drain();

    // Stall has priority over set_flags
    alu(64'h1, 1'b0, 1'b0, 1'b1);
    tick();
    expect_val("clear_0000", S_FLAGS, 4'b0000);
    drain();
    bus.stall = 1'b1;
    alu(64'h0, 1'b0, 1'b0, 1'b1);
    tick();
    expect_val("stall_hold", S_FLAGS, 4'b0000);
    drain();
    bus.stall = 1'b0;
    tick();
    expect_val("unstall_z", S_FLAGS, 4'b0100);
    drain();

    // Forwarding into B.LT (registered N=0 V=0)
    bus.br_type = 2'b01;
    alu(64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1);
    expect_val("fwd_blt_taken", S_BR, 4'b0001);
    settle();
    bus.stall = 1'b1;
    expect_val("stall_no_fwd", S_BR, 4'b0000);
    settle();
    bus.stall = 1'b0;
    tick();
    expect_val("fwd_same_edge_reg", S_FLAGS, 4'b1000);
    drain();
    bus.set_flags = 1'b0;
    expect_val("blt_registered_n", S_BR, 4'b0001);
    settle();

    // Branch types
    bus.br_type = 2'b00;
    expect_val("br_none", S_BR, 4'b0000);
    settle();
    bus.br_type   = 2'b11;
    bus.cbz_value = 64'hDEAD_BEEF;
    alu(64'h0, 1'b0, 1'b0, 1'b0);
    expect_val("br_always", S_BR, 4'b0001);
    settle();
    alu(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
    tick();
    expect_val("load_n1_v1", S_FLAGS, 4'b1001);
    drain();
    bus.set_flags = 1'b0;
    bus.br_type   = 2'b01;
    expect_val("blt_n1_v1", S_BR, 4'b0000);
    settle();
    bus.br_type   = 2'b10;
    bus.cbz_value = 64'h0;
    expect_val("cbz_ignores_flags", S_BR, 4'b0001);
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
